// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce filter, press/release/long-press strobes.
// Latency: btn_level and press/release pulses appear on the (2+DEBOUNCE_CYCLES)th edge after a pad change.
// Backpressure: none; free-running, every output is a registered level or one-cycle strobe.
//
// Ports:
//   clk            12 MHz system clock
//   rst            synchronous, active-high reset
//   btn_in         raw asynchronous button pad
//   btn_level      debounced level, 1 = pressed regardless of pad polarity
//   press_pulse    one-cycle strobe in the first cycle btn_level reads 1
//   release_pulse  one-cycle strobe in the first cycle btn_level reads 0
//   long_pulse     one-cycle strobe LONG_CYCLES cycles after press_pulse, once per press
//
// Build option: define LONG_PRESS_EN to build the long-press counter and LONG state.
// Without it the FSM is IDLE/PRESSED only and long_pulse is tied to 0.

module button_debounce #(
   parameter int ACTIVE_LOW      = 1,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int LONG_CYCLES     = 12000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   // Elaboration-time marker: an instance with illegal counts carries this block.
   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check_failed
   end

   localparam int            DW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   // Raw pad value while the button is released.
   localparam logic          REL_PAD  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   // ------------------------------------------------------------------
   // Synchroniser. Resetting to the released pad level means a button
   // held through reset still appears as a fresh transition afterwards.
   // ------------------------------------------------------------------
   logic sync_q1;
   logic sync_q2;
   logic p_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= REL_PAD;
         sync_q2 <= REL_PAD;
      end else begin
         sync_q1 <= btn_in;
         sync_q2 <= sync_q1;
      end
   end

   // Normalise polarity: 1 = pressed.
   assign p_sync = sync_q2 ^ REL_PAD;

   // ------------------------------------------------------------------
   // Debounce filter. Counts consecutive cycles where the synchronised
   // input disagrees with the accepted level; any agreeing cycle (a bounce
   // back) clears the count, so only an uninterrupted run is accepted.
   // ------------------------------------------------------------------
   logic [DW-1:0] deb_cnt;
   logic          deb_done;
   logic          deb_press;
   logic          deb_release;

   assign deb_done    = (p_sync != btn_level) && (deb_cnt == DEB_LAST);
   assign deb_press   = deb_done &  p_sync;
   assign deb_release = deb_done & ~p_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         deb_cnt   <= '0;
         btn_level <= 1'b0;
      end else if (p_sync == btn_level) begin
         deb_cnt   <= '0;
      end else if (deb_cnt == DEB_LAST) begin
         btn_level <= p_sync;
         deb_cnt   <= '0;
      end else begin
         deb_cnt   <= deb_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Press FSM. Strobes are computed combinationally from the debounce
   // events and registered, so they line up with the btn_level update.
   // ------------------------------------------------------------------
`ifdef LONG_PRESS_EN
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_LONG    = 2'd2
   } state_t;
`else
   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PRESSED = 1'b1
   } state_t;
`endif

   state_t state_q;
   state_t state_d;
   logic   press_d;
   logic   release_d;

`ifdef LONG_PRESS_EN
   localparam int            LW        = $clog2(LONG_CYCLES) + 1;
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] long_cnt;
   logic          long_d;
   logic          long_q;
`endif

   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef LONG_PRESS_EN
      long_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (deb_press) begin
               state_d = S_PRESSED;
               press_d = 1'b1;
            end
         end
         S_PRESSED: begin
            // Release wins over a coincident long-press terminal count.
            if (deb_release) begin
               state_d   = S_IDLE;
               release_d = 1'b1;
            end
`ifdef LONG_PRESS_EN
            else if (long_cnt == LONG_LAST) begin
               state_d = S_LONG;
               long_d  = 1'b1;
            end
`endif
         end
`ifdef LONG_PRESS_EN
         S_LONG: begin
            if (deb_release) begin
               state_d   = S_IDLE;
               release_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_q       <= state_d;
         press_pulse   <= press_d;
         release_pulse <= release_d;
      end
   end

`ifdef LONG_PRESS_EN
   // Hold-time counter: zeroed on press, advances only while PRESSED.
   // It leaves PRESSED at LONG_LAST, so LONG_CYCLES always fits and it
   // never wraps; it stays frozen in LONG and IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         long_cnt <= '0;
         long_q   <= 1'b0;
      end else begin
         long_q <= long_d;
         if (state_q == S_IDLE && deb_press) begin
            long_cnt <= '0;
         end else if (state_q == S_PRESSED) begin
            long_cnt <= long_cnt + 1'b1;
         end
      end
   end

   assign long_pulse = long_q;
`else
   assign long_pulse = 1'b0;
`endif

endmodule
